// File: rtl/regfile_dump_pkg.sv
// Shared types and constants for the register-file dump engine.
// Holds the FSM state encoding and register-file geometry.
package regfile_dump_pkg;

  localparam int unsigned REG_COUNT = 32;
  localparam int unsigned IDX_W     = 5;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StSend,
    StDone
  } state_e;

endpackage

// File: rtl/regfile_dump_if.sv
// Valid/ready output stream carrying one captured register per beat.
interface regfile_dump_if #(
  parameter int unsigned N = 64
) ();
  import regfile_dump_pkg::IDX_W;

  logic             dout_valid;
  logic             dout_ready;
  logic [N-1:0]     dout_data;
  logic [IDX_W-1:0] dout_idx;
  logic             dout_last;

  modport master (
    output dout_valid,
    output dout_data,
    output dout_idx,
    output dout_last,
    input  dout_ready
  );

  modport slave (
    input  dout_valid,
    input  dout_data,
    input  dout_idx,
    input  dout_last,
    output dout_ready
  );

endinterface

// File: rtl/regfile_dump.sv
// Walks a register range (wrapping at REG_COUNT), reading one register per beat and
// streaming its contents out over a valid/ready interface.
module regfile_dump
  import regfile_dump_pkg::state_e;
  import regfile_dump_pkg::StIdle;
  import regfile_dump_pkg::StRead;
  import regfile_dump_pkg::StSend;
  import regfile_dump_pkg::StDone;
  import regfile_dump_pkg::IDX_W;
#(
  parameter int unsigned N         = 64,
  parameter int unsigned REG_COUNT = regfile_dump_pkg::REG_COUNT
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [IDX_W-1:0]        first_idx,
  input  logic [IDX_W-1:0]        last_idx,
  output logic [IDX_W-1:0]        ra,
  input  logic [N-1:0]            rd,
  output logic                    busy,
  output logic                    done,
  regfile_dump_if.master          dout
);

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] last_q;
  logic [N-1:0]     data_q;
  logic [IDX_W-1:0] didx_q;
  logic             dlast_q;
  logic [IDX_W-1:0] idx_next;

  assign idx_next = (idx_q == IDX_W'(REG_COUNT - 1)) ? '0 : idx_q + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      last_q  <= '0;
      data_q  <= '0;
      didx_q  <= '0;
      dlast_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            idx_q   <= first_idx;
            last_q  <= last_idx;
            state_q <= StRead;
          end
        end
        StRead: begin
          // rd is combinational on ra, so this samples the register as of this cycle
          data_q  <= rd;
          didx_q  <= idx_q;
          dlast_q <= (idx_q == last_q);
          state_q <= StSend;
        end
        StSend: begin
          if (dout.dout_ready) begin
            if (dlast_q) begin
              state_q <= StDone;
            end else begin
              idx_q   <= idx_next;
              state_q <= StRead;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign ra              = idx_q;
  assign busy            = (state_q != StIdle);
  assign done            = (state_q == StDone);
  assign dout.dout_valid = (state_q == StSend);
  assign dout.dout_data  = data_q;
  assign dout.dout_idx   = didx_q;
  assign dout.dout_last  = dlast_q;

endmodule

// File: doc/regfile_dump.md
REGFILE_DUMP -- requirements
Module: regfile_dump

Interface
REQ-001 Parameter: N, default 64, width of register data in bits.
REQ-002 Parameter: REG_COUNT, default 32, number of architectural registers; index width 5 bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
REQ-006 first_idx  input  5  first register index of the dump, latched on accepted start.
REQ-007 last_idx  input  5  last register index of the dump, latched on accepted start.
REQ-008 ra  output  5  read address driven to the register file read port.
REQ-009 rd  input  N  read data returned combinationally by the register file for ra.
REQ-010 dout_valid  output  1  beat on dout_* is valid.
REQ-011 dout_ready  input  1  consumer accepts the beat when high together with dout_valid.
REQ-012 dout_data  output  N  captured register contents.
REQ-013 dout_idx  output  5  register index of the current beat.
REQ-014 dout_last  output  1  high on the final beat of the dump.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse after the final beat is accepted.

Function
REQ-017 FSM states IDLE, READ, SEND, DONE shall be implemented.
REQ-018 IDLE: on start=1, latch first_idx/last_idx, set current index to first_idx, go to READ; otherwise stay.
REQ-019 ra shall always equal the current index register.
REQ-020 READ: capture rd into dout_data, current index into dout_idx, (index==last) into dout_last, go to SEND.
REQ-021 SEND: dout_valid=1; on dout_ready=1, go to DONE if dout_last, else increment index modulo 32 and go to READ.
REQ-022 While dout_valid=1 and dout_ready=0, dout_data, dout_idx, dout_last shall hold stable.
REQ-023 DONE: done=1 for exactly one cycle, then IDLE.
REQ-024 Beat count shall be ((last_idx - first_idx) mod 32) + 1; first_idx==last_idx yields one beat; last_idx<first_idx wraps 31->0.
REQ-025 Throughput with dout_ready held high: one beat per 2 cycles; first dout_valid 2 cycles after accepted start.
REQ-026 start while busy=1 shall be ignored with no effect on the dump in progress.
REQ-027 Register-file writes occurring during a dump are not blocked; each beat reflects rd at its READ cycle.

Reset
REQ-028 reset_n low shall immediately force state IDLE, index 0, ra 0, dout_valid 0, dout_data 0, dout_idx 0, dout_last 0, busy 0, done 0.
REQ-029 Reset asserted mid-dump shall abort with no further beats; a start after release begins a fresh dump.

Structure
REQ-030 A shared package shall hold the FSM state enum typedef, REG_COUNT, and the 5-bit index width constant.
REQ-031 The block shall be a single module with no sub-module; the bench instantiates it with the existing regfile (ra->ra1, rd1->rd).

Verification (regfile reset contents Xi=i for i<31, X31=0)
REQ-032 first=0,last=31, ready=1 -> 32 beats, idx 0..31, data 0..30 then 0, dout_last only on idx 31, done one cycle after beat 31.
REQ-033 first=29,last=2 -> 6 beats idx 29,30,31,0,1,2 with data 29,30,0,0,1,2; last on idx 2.
REQ-034 first=last=7 -> exactly one beat, data 7, dout_last=1, done pulses once.
REQ-035 Backpressure: ready=0 for 3 cycles at beat idx 5 -> valid held high, data 5 and idx 5 stable, next beat idx 6 after ready.
REQ-036 Write X1=200 via regfile before dump first=0,last=3 -> beat idx 1 data 200; start pulsed mid-dump ignored (beat count 4).
REQ-037 reset_n low during beat idx 10 of a 0..31 dump -> outputs zero asynchronously; new dump 0..1 afterwards yields 2 correct beats.
